timer_bcd_display: RTL

- Consumer end of the millisecond timer output.
- Accepts a 16-bit binary count through a valid/ready handshake and converts it to four BCD digits with an iterative double-dabble engine (one shift per clock).
- Drives four active-low seven-segment digit outputs for the board HEX displays.
- Holds the last converted value stable on its outputs until the next conversion completes.

---
 rtl/timer_bcd_display.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/timer_bcd_display.sv
// timer_bcd_display
//   Consumer end of the millisecond timer. Accepts a 16-bit binary count over a
//   valid/ready handshake, clamps it to MAX_DISPLAY, converts it to four BCD
//   digits with an iterative double-dabble engine (one shift per clock) and
//   drives four active-low seven-segment digits. Outputs hold the last
//   committed value until the next conversion completes.
//
// Handshake: a transfer happens on any posedge clk where value_valid && ready.
//   ready is high only in IDLE; value_valid while ready is low is ignored and
//   is not queued. value is sampled only on the accepting edge.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   value        binary count to display
//   value_valid  request, sampled only while ready=1
//   ready        high in IDLE only
//   bcd          {thousands, hundreds, tens, ones}, registered
//   hex3..hex0   active-low segments {g,f,e,d,c,b,a}; hex3 = thousands
//   overflow     1 if the last accepted value exceeded MAX_DISPLAY
//   done         one-cycle pulse when new outputs are committed
//   state_o      current FSM state (debug)
module timer_bcd_display #(
    parameter bit          BLANK_LEADING = 1'b0,
    parameter logic [15:0] MAX_DISPLAY   = 16'd9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        ready,
    output logic [15:0] bcd,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        overflow,
    output logic        done,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Full display image {hex3,hex2,hex1,hex0} for a BCD value, including
    // optional leading-zero blanking. hex0 always shows its digit.
    function automatic logic [27:0] hex_of(input logic [15:0] b);
        logic [6:0] h3, h2, h1, h0;
        h3 = seg7(b[15:12]);
        h2 = seg7(b[11:8]);
        h1 = seg7(b[7:4]);
        h0 = seg7(b[3:0]);
        if (BLANK_LEADING) begin
            if (b[15:12] == 4'd0) h3 = SEG_BLANK;
            if (b[15:8]  == 8'd0) h2 = SEG_BLANK;
            if (b[15:4]  == 12'd0) h1 = SEG_BLANK;
        end
        return {h3, h2, h1, h0};
    endfunction

    state_t        state_q;
    logic [31:0]   shreg_q;
    logic [31:0]   shreg_d;
    logic [31:0]   adj_d;
    logic [4:0]    iter_q;
    logic          ovf_pending_q;
    logic [15:0]   bcd_q;
    logic [27:0]   hex_q;
    logic          overflow_q;
    logic          done_q;
    logic          over_max;
    logic [15:0]   clamped;

    assign over_max = (value > MAX_DISPLAY);
    assign clamped  = over_max ? MAX_DISPLAY : value;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        adj_d = shreg_q;
        for (int i = 0; i < 4; i++) begin
            if (shreg_q[16+4*i +: 4] >= 4'd5)
                adj_d[16+4*i +: 4] = shreg_q[16+4*i +: 4] + 4'd3;
        end
        shreg_d = adj_d << 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            iter_q        <= '0;
            ovf_pending_q <= 1'b0;
            bcd_q         <= '0;
            hex_q         <= hex_of(16'h0000);
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (value_valid) begin
                        shreg_q       <= {16'b0, clamped};
                        ovf_pending_q <= over_max;
                        iter_q        <= '0;
                        state_q       <= CONVERT;
                    end
                end
                CONVERT: begin
                    shreg_q <= shreg_d;
                    iter_q  <= iter_q + 5'd1;
                    // Sixteenth shift lands on this edge.
                    if (iter_q == 5'd15) state_q <= UPDATE;
                end
                UPDATE: begin
                    bcd_q      <= shreg_q[31:16];
                    hex_q      <= hex_of(shreg_q[31:16]);
                    overflow_q <= ovf_pending_q;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready    = (state_q == IDLE);
    assign bcd      = bcd_q;
    assign hex3     = hex_q[27:21];
    assign hex2     = hex_q[20:14];
    assign hex1     = hex_q[13:7];
    assign hex0     = hex_q[6:0];
    assign overflow = overflow_q;
    assign done     = done_q;
    assign state_o  = state_q;

endmodule
